// File: rtl/alu_operand_stage_if.sv
// Port bundle for the ID/EX operand stage. The stage takes the slave view.
// The decode/forwarding side, or a bench, takes the master view.
interface alu_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  // Decode-side handshake and operands
  logic            id_valid;
  logic            id_ready;
  logic [REGW-1:0] id_rs1_addr;
  logic [REGW-1:0] id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_use_imm;
  logic [3:0]      id_alu_sel;
  logic [REGW-1:0] id_rd_addr;
  logic            id_reg_write;

  // Forwarding sources
  logic            exm_reg_write;
  logic            exm_mem_read;
  logic [REGW-1:0] exm_rd_addr;
  logic [XLEN-1:0] exm_result;
  logic            wb_reg_write;
  logic [REGW-1:0] wb_rd_addr;
  logic [XLEN-1:0] wb_result;

  // Pipeline control and ALU-side outputs
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN:0]   A_in;
  logic [XLEN:0]   B_in;
  logic [3:0]      ALU_Sel;
  logic [REGW-1:0] ex_rd_addr;
  logic            ex_reg_write;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_alu_sel, id_rd_addr, id_reg_write,
           exm_reg_write, exm_mem_read, exm_rd_addr, exm_result,
           wb_reg_write, wb_rd_addr, wb_result, flush, ex_ready,
    input  id_ready, ex_valid, A_in, B_in, ALU_Sel, ex_rd_addr, ex_reg_write
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_alu_sel, id_rd_addr, id_reg_write,
           exm_reg_write, exm_mem_read, exm_rd_addr, exm_result,
           wb_reg_write, wb_rd_addr, wb_result, flush, ex_ready,
    output id_ready, ex_valid, A_in, B_in, ALU_Sel, ex_rd_addr, ex_reg_write
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the ALU.
// It resolves RAW hazards by forwarding from EX/MEM and then from MEM/WB.
// It stalls on a load-use hazard, and it picks register or immediate for operand B.
// It registers the operands with a valid/ready handshake and supports a flush.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic               clk,
  input  logic               reset,
  alu_operand_stage_if.slave bus
);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op_b;
  logic            load_hit_rs1;
  logic            load_hit_rs2;
  logic            hazard;
  logic            id_ready;
  logic            capture;

  logic            ex_valid_q;
  logic            ex_reg_write_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [3:0]      sel_q;
  logic [REGW-1:0] rd_q;

  // Source 1 resolve: x0 reads zero, EX/MEM beats MEM/WB, else regfile.
  always_comb begin
    // NOTE: the default assignment comes first, so every path drives rs1_fwd and no latch is inferred.
    rs1_fwd = bus.id_rs1_data;
    if (bus.id_rs1_addr == '0)
      rs1_fwd = '0;
    else if (bus.exm_reg_write && (bus.exm_rd_addr == bus.id_rs1_addr))
      rs1_fwd = bus.exm_result;
    else if (bus.wb_reg_write && (bus.wb_rd_addr == bus.id_rs1_addr))
      rs1_fwd = bus.wb_result;
  end

  // Source 2 resolve, same priority as source 1.
  always_comb begin
    rs2_fwd = bus.id_rs2_data;
    if (bus.id_rs2_addr == '0)
      rs2_fwd = '0;
    else if (bus.exm_reg_write && (bus.exm_rd_addr == bus.id_rs2_addr))
      rs2_fwd = bus.exm_result;
    else if (bus.wb_reg_write && (bus.wb_rd_addr == bus.id_rs2_addr))
      rs2_fwd = bus.wb_result;
  end

  // The immediate path bypasses forwarding entirely.
  assign op_b = bus.id_use_imm ? bus.id_imm : rs2_fwd;

  // A load in EX/MEM has no data yet, so a dependent instruction must wait.
  // rs2 only counts when it is actually consumed.
  assign load_hit_rs1 = (bus.exm_rd_addr == bus.id_rs1_addr);
  assign load_hit_rs2 = !bus.id_use_imm && (bus.exm_rd_addr == bus.id_rs2_addr);
  assign hazard       = bus.exm_mem_read && bus.exm_reg_write &&
                        (bus.exm_rd_addr != '0) && (load_hit_rs1 || load_hit_rs2);

  assign id_ready = (!ex_valid_q || bus.ex_ready) && !hazard && !bus.flush;
  assign capture  = bus.id_valid && id_ready;

  // Stage register: reset > flush > capture > drain; otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: operand registers are reset as well, because A_in/B_in are observable outputs that must read zero.
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      sel_q          <= '0;
      rd_q           <= '0;
    end else if (bus.flush) begin
      // NOTE: non-blocking assignments keep every register update in this block edge-consistent.
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
    end else if (capture) begin
      ex_valid_q     <= 1'b1;
      ex_reg_write_q <= bus.id_reg_write;
      a_q            <= rs1_fwd;
      b_q            <= op_b;
      sel_q          <= bus.id_alu_sel;
      rd_q           <= bus.id_rd_addr;
    end else if (ex_valid_q && bus.ex_ready) begin
      // Bubble: the data fields keep their last value; only the valid bit and the write enable drop.
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
    end
  end

  assign bus.id_ready     = id_ready;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.A_in         = {1'b0, a_q};
  assign bus.B_in         = {1'b0, b_q};
  assign bus.ALU_Sel      = sel_q;
  assign bus.ex_rd_addr   = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage.
// Expected ALU-side results are queued when an instruction is accepted.
// They are popped and compared when the stage hands that instruction to EX.
module tb_alu_operand_stage;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef struct {
    logic [XLEN:0]   a;
    logic [XLEN:0]   b;
    logic [3:0]      sel;
    logic [REGW-1:0] rd;
    logic            rw;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  alu_operand_stage_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

  alu_operand_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic push(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [3:0] sel, input logic [REGW-1:0] rd, input logic rw);
    exp_t e;
    e.a   = {1'b0, a};
    e.b   = {1'b0, b};
    e.sel = sel;
    e.rd  = rd;
    e.rw  = rw;
    sb_q.push_back(e);
  endtask

  // Settle to the falling edge and compare a handed-off instruction against the scoreboard.
  task automatic half();
    exp_t e;
    @(negedge clk);
    if (bus.ex_valid && bus.ex_ready) begin
      chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("out_A_in",    64'(bus.A_in),         64'(e.a));
        chk("out_B_in",    64'(bus.B_in),         64'(e.b));
        chk("out_ALU_Sel", 64'(bus.ALU_Sel),      64'(e.sel));
        chk("out_rd",      64'(bus.ex_rd_addr),   64'(e.rd));
        chk("out_rw",      64'(bus.ex_reg_write), 64'(e.rw));
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid      = 1'b0;
    bus.id_rs1_addr   = '0;
    bus.id_rs2_addr   = '0;
    bus.id_rs1_data   = '0;
    bus.id_rs2_data   = '0;
    bus.id_imm        = '0;
    bus.id_use_imm    = 1'b0;
    bus.id_alu_sel    = '0;
    bus.id_rd_addr    = '0;
    bus.id_reg_write  = 1'b0;
    bus.exm_reg_write = 1'b0;
    bus.exm_mem_read  = 1'b0;
    bus.exm_rd_addr   = '0;
    bus.exm_result    = '0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_rd_addr    = '0;
    bus.wb_result     = '0;
    bus.flush         = 1'b0;
    bus.ex_ready      = 1'b1;
  endtask

  task automatic issue(input logic [REGW-1:0] rs1, input logic [XLEN-1:0] d1,
                       input logic [REGW-1:0] rs2, input logic [XLEN-1:0] d2,
                       input logic [XLEN-1:0] imm, input logic use_imm,
                       input logic [3:0] sel, input logic [REGW-1:0] rd, input logic rw);
    bus.id_valid     = 1'b1;
    bus.id_rs1_addr  = rs1;
    bus.id_rs1_data  = d1;
    bus.id_rs2_addr  = rs2;
    bus.id_rs2_data  = d2;
    bus.id_imm       = imm;
    bus.id_use_imm   = use_imm;
    bus.id_alu_sel   = sel;
    bus.id_rd_addr   = rd;
    bus.id_reg_write = rw;
  endtask

  task automatic fwd(input logic exm_rw, input logic exm_mr, input logic [REGW-1:0] exm_rd,
                     input logic [XLEN-1:0] exm_res, input logic wb_rw,
                     input logic [REGW-1:0] wb_rd, input logic [XLEN-1:0] wb_res);
    bus.exm_reg_write = exm_rw;
    bus.exm_mem_read  = exm_mr;
    bus.exm_rd_addr   = exm_rd;
    bus.exm_result    = exm_res;
    bus.wb_reg_write  = wb_rw;
    bus.wb_rd_addr    = wb_rd;
    bus.wb_result     = wb_res;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex_valid"}, 64'(bus.ex_valid),     64'd0);
    chk({tag, "_A_in"},     64'(bus.A_in),         64'd0);
    chk({tag, "_B_in"},     64'(bus.B_in),         64'd0);
    chk({tag, "_ALU_Sel"},  64'(bus.ALU_Sel),      64'd0);
    chk({tag, "_rd"},       64'(bus.ex_rd_addr),   64'd0);
    chk({tag, "_rw"},       64'(bus.ex_reg_write), 64'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    edge_step();

    // 1: plain capture with an immediate operand B
    issue(5'd3, 32'h10, 5'd7, 32'h99, 32'h5, 1'b1, 4'b0010, 5'd8, 1'b1);
    half();
    chk("t1_id_ready", 64'(bus.id_ready), 64'd1);
    push(32'h10, 32'h5, 4'b0010, 5'd8, 1'b1);
    edge_step();
    bus.id_valid = 1'b0;
    half();
    chk("t1_ex_valid", 64'(bus.ex_valid), 64'd1);
    edge_step();
    half();
    chk("t1_bubble_valid", 64'(bus.ex_valid),     64'd0);
    chk("t1_bubble_rw",    64'(bus.ex_reg_write), 64'd0);
    chk("t1_bubble_hold",  64'(bus.A_in),         64'h10);
    edge_step();

    // 2: forwarding priority, EX/MEM over MEM/WB, on both sources
    issue(5'd4, 32'h11, 5'd0, 32'h0, 32'h3, 1'b1, 4'h3, 5'd9, 1'b1);
    fwd(1'b1, 1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
    half();
    push(32'hAA, 32'h3, 4'h3, 5'd9, 1'b1);
    edge_step();
    bus.exm_reg_write = 1'b0;
    half();
    push(32'hBB, 32'h3, 4'h3, 5'd9, 1'b1);
    edge_step();
    issue(5'd2, 32'h20, 5'd4, 32'h44, 32'h0, 1'b0, 4'h4, 5'd10, 1'b0);
    half();
    push(32'h20, 32'hBB, 4'h4, 5'd10, 1'b0);
    edge_step();
    bus.exm_reg_write = 1'b1;
    half();
    push(32'h20, 32'hAA, 4'h4, 5'd10, 1'b0);
    edge_step();

    // 3: x0 never forwards; top bit of each operand is always 0
    issue(5'd0, 32'h7, 5'd0, 32'h5, 32'h0, 1'b0, 4'hA, 5'd1, 1'b1);
    fwd(1'b1, 1'b0, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    half();
    push(32'h0, 32'h0, 4'hA, 5'd1, 1'b1);
    edge_step();
    issue(5'd1, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000, 32'h0, 1'b0, 4'hF, 5'd31, 1'b1);
    fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    half();
    push(32'hFFFF_FFFF, 32'h8000_0000, 4'hF, 5'd31, 1'b1);
    edge_step();
    bus.id_valid = 1'b0;
    half();
    edge_step();

    // 4: load-use stall on rs2, then imm bypass, then forward once the load resolves
    issue(5'd1, 32'h1, 5'd5, 32'h2, 32'h9, 1'b0, 4'h6, 5'd12, 1'b1);
    fwd(1'b1, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    half();
    chk("t4_id_ready_hz", 64'(bus.id_ready), 64'd0);
    edge_step();
    half();
    chk("t4_ex_valid_hz", 64'(bus.ex_valid), 64'd0);
    chk("t4_id_ready_hz2", 64'(bus.id_ready), 64'd0);
    edge_step();
    bus.id_use_imm = 1'b1;
    half();
    chk("t4_id_ready_imm", 64'(bus.id_ready), 64'd1);
    push(32'h1, 32'h9, 4'h6, 5'd12, 1'b1);
    edge_step();
    bus.id_use_imm   = 1'b0;
    bus.exm_mem_read = 1'b0;
    half();
    chk("t4_id_ready_clr", 64'(bus.id_ready), 64'd1);
    push(32'h1, 32'h55, 4'h6, 5'd12, 1'b1);
    edge_step();
    idle();
    half();
    edge_step();

    // 5: back-pressure holds outputs for 3 cycles; the next instruction waits
    issue(5'd10, 32'h100, 5'd0, 32'h0, 32'h7, 1'b1, 4'h5, 5'd11, 1'b1);
    half();
    push(32'h100, 32'h7, 4'h5, 5'd11, 1'b1);
    edge_step();
    issue(5'd12, 32'h200, 5'd0, 32'h0, 32'h8, 1'b1, 4'h6, 5'd13, 1'b0);
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half();
      chk("t5_id_ready", 64'(bus.id_ready), 64'd0);
      chk("t5_ex_valid", 64'(bus.ex_valid), 64'd1);
      chk("t5_A_hold",   64'(bus.A_in),     64'h100);
      chk("t5_sel_hold", 64'(bus.ALU_Sel),  64'h5);
      edge_step();
    end
    bus.ex_ready = 1'b1;
    half();
    chk("t5_id_ready_go", 64'(bus.id_ready), 64'd1);
    push(32'h200, 32'h8, 4'h6, 5'd13, 1'b0);
    edge_step();
    bus.id_valid = 1'b0;
    half();
    edge_step();

    // 6: flush squashes both the held and the incoming instruction
    issue(5'd14, 32'h300, 5'd0, 32'h0, 32'h1, 1'b1, 4'h1, 5'd14, 1'b1);
    half();
    push(32'h300, 32'h1, 4'h1, 5'd14, 1'b1);
    edge_step();
    issue(5'd15, 32'h301, 5'd0, 32'h0, 32'h2, 1'b1, 4'h2, 5'd15, 1'b1);
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b1;
    half();
    chk("t6_id_ready_flush", 64'(bus.id_ready), 64'd0);
    edge_step();
    sb_q.delete(0);
    idle();
    half();
    chk("t6_ex_valid_flush", 64'(bus.ex_valid),     64'd0);
    chk("t6_rw_flush",       64'(bus.ex_reg_write), 64'd0);
    edge_step();

    // Reset asserted mid-stall clears outputs without waiting for a clock
    issue(5'd6, 32'h400, 5'd0, 32'h0, 32'h4, 1'b1, 4'h9, 5'd6, 1'b1);
    half();
    push(32'h400, 32'h4, 4'h9, 5'd6, 1'b1);
    edge_step();
    idle();
    bus.ex_ready = 1'b0;
    half();
    chk("t6_ex_valid_stall", 64'(bus.ex_valid), 64'd1);
    chk("t6_A_stall",        64'(bus.A_in),     64'h400);
    edge_step();
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("t6_async_reset");
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    bus.ex_ready = 1'b1;
    edge_step();

    // Recovery after reset
    issue(5'd3, 32'h12, 5'd0, 32'h0, 32'h34, 1'b1, 4'h7, 5'd3, 1'b1);
    half();
    push(32'h12, 32'h34, 4'h7, 5'd3, 1'b1);
    edge_step();
    idle();
    half();
    edge_step();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
